link_tx_scheduler: RTL and testbench

- Schedules every outbound message from this board to the peer board over one serial wire.
- Arbitrates four requesters onto that wire: connect level, start level, game-finish pulse, and sudoku cell updates.
- Sits between the stage FSM outputs (send_connect, send_start), game logic (game_finish, cell writes) and the FPGA-to-FPGA pin.
- The receive side decodes the same frame format into receive_connect / receive_start / receive_game_finish.

---
 rtl/link_tx_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_link_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// link_tx_scheduler
//
// Serialises every board-to-board message onto a single UART-like wire.
// Four requesters share the wire with fixed priority:
//   connect level change > start level change > game finish > cell update.
//
// Frame (18 bits, LSB first, each bit held CLK_DIV cycles):
//   [0] start=0 | [4:1] type | [15:5] payload | [16] even parity | [17] stop=1
// Every frame is followed by GAP_BITS idle-high bit times, then one IDLE
// cycle in which the next request is arbitrated.
//
// Ports
//   clk, reset      system clock, synchronous active-low reset
//   send_connect    connect level from the stage FSM
//   send_start      start level from the stage FSM
//   game_finish     one-cycle "local board solved" pulse
//   cell_valid/index/value, cell_ready   cell update handshake
//   tx              serial line, idle high
//   busy            frame or trailing gap in progress
//   drop_err        one-cycle pulse after a cell with index > 80 is discarded
// ---------------------------------------------------------------------------
module link_tx_scheduler #(
    parameter int CLK_DIV  = 868,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_connect,
    input  logic       send_start,
    input  logic       game_finish,
    input  logic       cell_valid,
    input  logic [6:0] cell_index,
    input  logic [3:0] cell_value,
    output logic       cell_ready,
    output logic       tx,
    output logic       busy,
    output logic       drop_err
);

    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [4:0]    LAST_BIT = 5'd17;

    localparam logic [3:0] T_CONNECT = 4'd1;
    localparam logic [3:0] T_START   = 4'd2;
    localparam logic [3:0] T_FINISH  = 4'd3;
    localparam logic [3:0] T_CELL    = 4'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [17:0]     frame_q, frame_d;
    logic [4:0]      bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            conn_sh_q, conn_sh_d;
    logic            start_sh_q, start_sh_d;
    logic            fin_pend_q, fin_pend_d;
    logic            drop_q, drop_d;

    logic            load;
    logic [3:0]      ld_type;
    logic [10:0]     ld_payload;
    logic            conn_chg, start_chg;

    // A level request is a mismatch against the value last put on the wire;
    // the shadow only moves when that level's frame is loaded, so a level
    // that bounces back during a frame leaves no request behind.
    assign conn_chg  = send_connect != conn_sh_q;
    assign start_chg = send_start   != start_sh_q;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        div_d      = div_q;
        gap_d      = gap_q;
        conn_sh_d  = conn_sh_q;
        start_sh_d = start_sh_q;
        // A pulse arriving on the very cycle FINISH is loaded re-arms the
        // flag, producing a second FINISH frame.
        fin_pend_d = fin_pend_q | game_finish;
        drop_d     = 1'b0;
        cell_ready = 1'b0;
        load       = 1'b0;
        ld_type    = 4'd0;
        ld_payload = 11'd0;

        case (state_q)
            IDLE: begin
                if (conn_chg) begin
                    load       = 1'b1;
                    ld_type    = T_CONNECT;
                    ld_payload = {10'd0, send_connect};
                    conn_sh_d  = send_connect;
                end else if (start_chg) begin
                    load       = 1'b1;
                    ld_type    = T_START;
                    ld_payload = {10'd0, send_start};
                    start_sh_d = send_start;
                end else if (fin_pend_q) begin
                    load       = 1'b1;
                    ld_type    = T_FINISH;
                    fin_pend_d = game_finish;
                end else if (cell_valid) begin
                    cell_ready = 1'b1;
                    // Out-of-range cells are consumed but never sent.
                    if (cell_index > 7'd80) begin
                        drop_d = 1'b1;
                    end else begin
                        load       = 1'b1;
                        ld_type    = T_CELL;
                        ld_payload = {cell_index, cell_value};
                    end
                end

                if (load) begin
                    frame_d = {1'b1, ^{ld_type, ld_payload}, ld_payload, ld_type, 1'b0};
                    bit_d   = 5'd0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    // Shift in ones so the line rests high once drained.
                    frame_d = {1'b1, frame_q[17:1]};
                    if (bit_q == LAST_BIT) begin
                        gap_d   = '0;
                        state_d = (GAP_CYC > 0) ? GAP : IDLE;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            frame_q    <= '1;
            bit_q      <= 5'd0;
            div_q      <= '0;
            gap_q      <= '0;
            conn_sh_q  <= 1'b0;
            start_sh_q <= 1'b0;
            fin_pend_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            conn_sh_q  <= conn_sh_d;
            start_sh_q <= start_sh_d;
            fin_pend_q <= fin_pend_d;
            drop_q     <= drop_d;
        end
    end

    assign tx       = (state_q == SHIFT) ? frame_q[0] : 1'b1;
    assign busy     = state_q != IDLE;
    assign drop_err = drop_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for link_tx_scheduler (CLK_DIV=4, GAP_BITS=2).
// A frame-level model (priority pick + "cycles since load") predicts tx, busy,
// cell_ready and drop_err every cycle; a line decoder recovers whole frames
// from tx so directed tests can pin them against literal bit patterns.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
// ---------------------------------------------------------------------------
module tb_link_tx_scheduler;

    localparam int CD   = 4;
    localparam int GB   = 2;
    localparam int FLEN = 18 * CD;        // cycles carrying frame bits
    localparam int PER  = (18 + GB) * CD; // busy cycles per frame

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send_connect = 1'b1;
    logic       send_start = 1'b1;
    logic       game_finish = 1'b0;
    logic       cell_valid = 1'b0;
    logic [6:0] cell_index = 7'd0;
    logic [3:0] cell_value = 4'd0;
    logic       cell_ready, tx, busy, drop_err;

    always #5 clk = ~clk;

    link_tx_scheduler #(.CLK_DIV(CD), .GAP_BITS(GB)) dut (
        .clk         (clk),
        .reset       (reset),
        .send_connect(send_connect),
        .send_start  (send_start),
        .game_finish (game_finish),
        .cell_valid  (cell_valid),
        .cell_index  (cell_index),
        .cell_value  (cell_value),
        .cell_ready  (cell_ready),
        .tx          (tx),
        .busy        (busy),
        .drop_err    (drop_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [17:0] mk_frame(input logic [3:0] ty, input logic [10:0] pl);
        logic [17:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            f[1+i] = ty[i];
            ones += int'(ty[i]);
        end
        for (int i = 0; i < 11; i++) begin
            f[5+i] = pl[i];
            ones += int'(pl[i]);
        end
        f[16] = (ones % 2) == 1;
        f[17] = 1'b1;
        return f;
    endfunction

    // ---------------- frame-level model ----------------
    bit          started = 0;
    bit          m_active = 0;
    int          m_t = 0;
    logic [17:0] m_frame = '1;
    bit          m_csh = 0, m_ssh = 0, m_fin = 0, m_drop = 0;
    bit          fin_n;

    initial forever begin
        @(posedge clk);
        started = 1;
        if (!reset) begin
            m_active = 0; m_t = 0; m_csh = 0; m_ssh = 0; m_fin = 0; m_drop = 0;
        end else begin
            fin_n  = m_fin | game_finish;
            m_drop = 0;
            if (m_active) begin
                m_t++;
                if (m_t == PER) m_active = 0;
            end else if (send_connect != m_csh) begin
                m_frame = mk_frame(4'd1, {10'd0, send_connect});
                m_csh = send_connect; m_active = 1; m_t = 0;
            end else if (send_start != m_ssh) begin
                m_frame = mk_frame(4'd2, {10'd0, send_start});
                m_ssh = send_start; m_active = 1; m_t = 0;
            end else if (m_fin) begin
                m_frame = mk_frame(4'd3, 11'd0);
                fin_n = game_finish; m_active = 1; m_t = 0;
            end else if (cell_valid) begin
                if (cell_index > 7'd80) m_drop = 1;
                else begin
                    m_frame = mk_frame(4'd4, {cell_index, cell_value});
                    m_active = 1; m_t = 0;
                end
            end
            m_fin = fin_n;
        end
    end

    // ---------------- per-cycle compare + line decoder ----------------
    logic        exp_tx, exp_rdy;
    logic [17:0] obs_q[$];
    int          start_cyc_q[$];
    int          cyc = 0;
    bit          dec_on = 0;
    int          dec_n = 0;
    logic [17:0] dec_f = '0;
    int          bw_cur = 0, bw_last = 0;
    int          rdy_cnt = 0, drop_cnt = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (started) begin
            exp_tx  = (m_active && m_t < FLEN) ? m_frame[m_t / CD] : 1'b1;
            exp_rdy = !m_active && cell_valid && (send_connect == m_csh) &&
                      (send_start == m_ssh) && !m_fin;
            chk("cyc_tx", 32'(tx), 32'(exp_tx));
            chk("cyc_busy", 32'(busy), 32'(m_active));
            chk("cyc_cell_ready", 32'(cell_ready), 32'(exp_rdy));
            chk("cyc_drop_err", 32'(drop_err), 32'(m_drop));
        end
        if (cell_ready === 1'b1) rdy_cnt++;
        if (drop_err === 1'b1) drop_cnt++;
        if (busy === 1'b1) bw_cur++;
        else begin
            if (bw_cur > 0) bw_last = bw_cur;
            bw_cur = 0;
        end
        if (!reset) dec_on = 0;
        else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on = 1; dec_n = 0; dec_f = '0;
                start_cyc_q.push_back(cyc);
            end
        end else dec_n++;
        if (dec_on && (dec_n % CD) == CD / 2) begin
            dec_f[dec_n / CD] = tx;
            if (dec_n / CD == 17) begin
                obs_q.push_back(dec_f);
                dec_on = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        start_cyc_q.delete();
    endtask

    task automatic wait_quiet(input string nm);
        int q, k;
        q = 0; k = 0;
        while (q < 5 && k < 3000) begin
            tick(1); k++;
            if (busy === 1'b0) q++; else q = 0;
        end
        chk(nm, 32'(k < 3000), 32'd1);
    endtask

    task automatic cell_req(input logic [6:0] idx, input logic [3:0] val, input bit fin_too);
        bit got;
        int k;
        got = 0; k = 0;
        cell_index = idx; cell_value = val; cell_valid = 1'b1;
        if (fin_too) game_finish = 1'b1;
        while (!got && k < 3000) begin
            @(negedge clk);
            got = cell_ready;
            @(posedge clk); #1;
            game_finish = 1'b0;
            k++;
        end
        cell_valid = 1'b0;
        chk("cell_handshake", 32'(got), 32'd1);
    endtask

    task automatic pulse_finish();
        game_finish = 1'b1;
        tick(1);
        game_finish = 1'b0;
    endtask

    // Hand-computed frames: {stop, parity, payload, type, start}
    localparam logic [17:0] F_CONN1 = {1'b1, 1'b0, 11'h001, 4'b0001, 1'b0};
    localparam logic [17:0] F_STRT1 = {1'b1, 1'b0, 11'h001, 4'b0010, 1'b0};
    localparam logic [17:0] F_FIN   = {1'b1, 1'b0, 11'h000, 4'b0011, 1'b0};
    localparam logic [17:0] F_C40_7 = {1'b1, 1'b0, 11'h287, 4'b0100, 1'b0};
    localparam logic [17:0] F_C5_2  = {1'b1, 1'b0, 11'h052, 4'b0100, 1'b0};

    initial begin
        int bad, k;

        // Reset release with both levels already high.
        tick(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        wait_quiet("t1_done");
        chk("t1_nframes", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("t1_connect_frame", 32'(obs_q[0]), 32'(F_CONN1));
            chk("t1_start_frame", 32'(obs_q[1]), 32'(F_STRT1));
            // 80 busy cycles plus the one IDLE arbitration cycle
            chk("t1_frame_spacing", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd81);
        end
        chk("t1_busy_width", 32'(bw_last), 32'd80);

        send_connect = 1'b0; send_start = 1'b0;
        wait_quiet("t1b_done");
        clear_obs();

        // Arbitration: start change, finish pulse and cell in the same cycle.
        rdy_cnt = 0;
        send_start = 1'b1;
        cell_req(7'd40, 4'd7, 1'b1);
        wait_quiet("t2_done");
        chk("t2_nframes", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("t2_first_start", 32'(obs_q[0]), 32'(F_STRT1));
            chk("t2_second_finish", 32'(obs_q[1]), 32'(F_FIN));
            chk("t2_third_cell", 32'(obs_q[2]), 32'(F_C40_7));
        end
        chk("t2_ready_cycles", 32'(rdy_cnt), 32'd1);
        clear_obs();

        // Finish merge, then a pulse on the FINISH load cycle.
        cell_req(7'd5, 4'd2, 1'b0);
        tick(10); pulse_finish();
        tick(10); pulse_finish();
        tick(10); pulse_finish();
        k = 0;
        while (busy !== 1'b0 && k < 500) begin tick(1); k++; end
        chk("t3_idle_reached", 32'(k < 500), 32'd1);
        pulse_finish();
        wait_quiet("t3_done");
        chk("t3_nframes", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("t3_cell", 32'(obs_q[0]), 32'(F_C5_2));
            chk("t3_finish_a", 32'(obs_q[1]), 32'(F_FIN));
            chk("t3_finish_b", 32'(obs_q[2]), 32'(F_FIN));
        end
        clear_obs();

        // Bad index is consumed and flagged, nothing sent.
        drop_cnt = 0;
        cell_index = 7'd100; cell_value = 4'd3; cell_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready", 32'(cell_ready), 32'd1);
        @(posedge clk); #1;
        cell_valid = 1'b0;
        @(negedge clk);
        chk("t4_drop_err", 32'(drop_err), 32'd1);
        chk("t4_tx", 32'(tx), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        tick(100);
        chk("t4_nframes", 32'(obs_q.size()), 32'd0);
        chk("t4_drop_cycles", 32'(drop_cnt), 32'd1);

        // Connect glitch inside a frame leaves no CONNECT frame.
        cell_req(7'd9, 4'd9, 1'b0);
        tick(10); send_connect = 1'b1;
        tick(10); send_connect = 1'b0;
        wait_quiet("t5_done");
        chk("t5_nframes", 32'(obs_q.size()), 32'd1);
        clear_obs();

        // Reset in the middle of bit 9 of a CELL frame.
        send_start = 1'b0;
        wait_quiet("t6_pre");
        clear_obs();
        cell_req(7'd40, 4'd7, 1'b0);
        tick(38);
        reset = 1'b0;
        tick(1);
        chk("t6_tx", 32'(tx), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(cell_ready), 32'd0);
        tick(2);
        reset = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("t6_tx_idle", 32'(bad), 32'd0);
        chk("t6_nframes", 32'(obs_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
